// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and round helper functions for the compression datapath.
package sha256_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t K62 = 32'hbef9a3f7;
    localparam word_t K63 = 32'hc67178f2;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t big_sigma0(input word_t x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round_comb.sv
// Combinational single SHA-256 round: {a..h} plus round constant K and word W to next {a..h}.
module sha256_round_comb
    import sha256_pkg::*;
#(
    parameter word_t K = 32'h0
) (
    input  logic [255:0] i_state,
    input  logic [31:0]  i_w,
    output logic [255:0] o_state
);

    word_t w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    word_t w_t1, w_t2;

    always_comb begin
        {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;
        w_t1    = w_h + big_sigma1(w_e) + ch(w_e, w_f, w_g) + K + i_w;
        w_t2    = big_sigma0(w_a) + maj(w_a, w_b, w_c);
        o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};
    end

endmodule

// File: rtl/sha256_round_pipeline_62_63.sv
// Rounds 62/63 plus chaining-value feed-forward, three enabled register stages.
// Optional target comparator (hit output) is built when SHA256_TARGET_CMP_EN is defined.
module sha256_round_pipeline_62_63
    import sha256_pkg::*;
#(
    parameter int unsigned TAG_W     = 32,
    parameter int unsigned ZERO_BITS = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             write_en,
    input  logic             valid_in,
    input  logic [255:0]     state_in,
    input  logic [31:0]      w62,
    input  logic [31:0]      w63,
    input  logic [255:0]     h_init,
    input  logic [TAG_W-1:0] tag_in,
    output logic             valid_out,
    output logic [255:0]     digest,
    output logic [TAG_W-1:0] tag_out
`ifdef SHA256_TARGET_CMP_EN
    ,
    output logic             hit
`endif
);

    if (ZERO_BITS < 1 || ZERO_BITS > 256) begin : g_zero_bits_range
        $error("ZERO_BITS must be within 1..256");
    end

    logic [255:0]     w_s1_state, w_s2_state, w_digest;

    logic             r_s1_valid, r_s2_valid, r_s3_valid;
    logic [255:0]     r_s1_state, r_s2_state, r_s3_digest;
    logic [31:0]      r_s1_w63;
    logic [255:0]     r_s1_hinit, r_s2_hinit;
    logic [TAG_W-1:0] r_s1_tag, r_s2_tag, r_s3_tag;

    sha256_round_comb #(
        .K (K62)
    ) u_round62 (
        .i_state (state_in),
        .i_w     (w62),
        .o_state (w_s1_state)
    );

    sha256_round_comb #(
        .K (K63)
    ) u_round63 (
        .i_state (r_s1_state),
        .i_w     (r_s1_w63),
        .o_state (w_s2_state)
    );

    // Feed-forward is lane-wise: carries never cross a 32-bit word boundary.
    always_comb begin
        w_digest = '0;
        for (int i = 0; i < 8; i++) begin
            w_digest[i*32 +: 32] = r_s2_state[i*32 +: 32] + r_s2_hinit[i*32 +: 32];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s1_valid  <= 1'b0;
            r_s1_state  <= '0;
            r_s1_w63    <= '0;
            r_s1_hinit  <= '0;
            r_s1_tag    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_state  <= '0;
            r_s2_hinit  <= '0;
            r_s2_tag    <= '0;
            r_s3_valid  <= 1'b0;
            r_s3_digest <= '0;
            r_s3_tag    <= '0;
        end else if (write_en) begin
            r_s1_valid  <= valid_in;
            r_s1_state  <= w_s1_state;
            r_s1_w63    <= w63;
            r_s1_hinit  <= h_init;
            r_s1_tag    <= tag_in;
            r_s2_valid  <= r_s1_valid;
            r_s2_state  <= w_s2_state;
            r_s2_hinit  <= r_s1_hinit;
            r_s2_tag    <= r_s1_tag;
            r_s3_valid  <= r_s2_valid;
            r_s3_digest <= w_digest;
            r_s3_tag    <= r_s2_tag;
        end
    end

    assign valid_out = r_s3_valid;
    assign digest    = r_s3_digest;
    assign tag_out   = r_s3_tag;

`ifdef SHA256_TARGET_CMP_EN
    logic w_hit;
    logic r_s3_hit;

    assign w_hit = r_s2_valid && (w_digest[255 -: ZERO_BITS] == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s3_hit <= 1'b0;
        end else if (write_en) begin
            r_s3_hit <= w_hit;
        end
    end

    assign hit = r_s3_hit;
`endif

endmodule

// File: tb/tb_sha256_round_pipeline_62_63.sv
// Directed bench for sha256_round_pipeline_62_63: FIPS "abc", streaming, stall, bubbles, reset.
module tb_sha256_round_pipeline_62_63;

    localparam int unsigned TAG_W     = 32;
    localparam int unsigned ZERO_BITS = 8;

    logic             CLK;
    logic             RST;
    logic             write_en;
    logic             valid_in;
    logic [255:0]     state_in;
    logic [31:0]      w62;
    logic [31:0]      w63;
    logic [255:0]     h_init;
    logic [TAG_W-1:0] tag_in;
    logic             valid_out;
    logic [255:0]     digest;
    logic [TAG_W-1:0] tag_out;
`ifdef SHA256_TARGET_CMP_EN
    logic             hit;
`endif

    sha256_round_pipeline_62_63 #(
        .TAG_W     (TAG_W),
        .ZERO_BITS (ZERO_BITS)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .write_en  (write_en),
        .valid_in  (valid_in),
        .state_in  (state_in),
        .w62       (w62),
        .w63       (w63),
        .h_init    (h_init),
        .tag_in    (tag_in),
        .valid_out (valid_out),
        .digest    (digest),
        .tag_out   (tag_out)
`ifdef SHA256_TARGET_CMP_EN
        ,
        .hit       (hit)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [255:0] s, input logic [31:0] x62,
                         input logic [31:0] x63, input logic [255:0] hi, input logic [31:0] t);
        valid_in = v;
        state_in = s;
        w62      = x62;
        w63      = x63;
        h_init   = hi;
        tag_in   = t;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] rnd(input logic [255:0] s, input logic [31:0] k,
                                         input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] tail(input logic [255:0] s, input logic [31:0] x62,
                                          input logic [31:0] x63);
        return rnd(rnd(s, 32'hbef9a3f7, x62), 32'hc67178f2, x63);
    endfunction

    function automatic logic [255:0] model(input logic [255:0] s, input logic [31:0] x62,
                                           input logic [31:0] x63, input logic [255:0] hi);
        logic [255:0] f, o;
        f = tail(s, x62, x63);
        for (int i = 0; i < 8; i++) o[i*32 +: 32] = f[i*32 +: 32] + hi[i*32 +: 32];
        return o;
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [31:0]  k_tab [64];
    logic [31:0]  wsch  [64];
    logic [255:0] iv;
    logic [255:0] st61;
    logic [255:0] abc_digest;
    logic [31:0]  s0, s1;

    logic [255:0] b_s  [8];
    logic [31:0]  b_62 [8];
    logic [31:0]  b_63 [8];
    logic [255:0] b_h  [8];
    logic [255:0] b_d  [8];
    logic         pat  [5];

    initial begin
        k_tab = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
            32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
            32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
            32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
            32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
            32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
            32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
            32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
            32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };
        iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        abc_digest = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

        // Padded single block for the message "abc"
        for (int t = 0; t < 16; t++) wsch[t] = 32'h0;
        wsch[0]  = 32'h61626380;
        wsch[15] = 32'h00000018;
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(wsch[t-15], 7) ^ rotr(wsch[t-15], 18) ^ (wsch[t-15] >> 3);
            s1 = rotr(wsch[t-2], 17) ^ rotr(wsch[t-2], 19) ^ (wsch[t-2] >> 10);
            wsch[t] = s1 + wsch[t-7] + s0 + wsch[t-16];
        end
        st61 = iv;
        for (int t = 0; t < 62; t++) st61 = rnd(st61, k_tab[t], wsch[t]);

        // Reset state
        RST      = 1'b1;
        write_en = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0);
        repeat (2) step();
        chk("rst_valid", 256'(valid_out), 256'(1'b0));
        chk("rst_digest", digest, 256'h0);
        chk("rst_tag", 256'(tag_out), 256'h0);
`ifdef SHA256_TARGET_CMP_EN
        chk("rst_hit", 256'(hit), 256'(1'b0));
`endif

        // FIPS 180-4 "abc" tail; release reset with write_en already high
        RST      = 1'b0;
        write_en = 1'b1;
        drive(1'b1, st61, wsch[62], wsch[63], iv, 32'h0000abcd);
        step();
        drive(1'b0, '0, '0, '0, '0, '0);
        step();
        chk("abc_not_early", 256'(valid_out), 256'(1'b0));
        step();
        chk("abc_valid", 256'(valid_out), 256'(1'b1));
        chk("abc_tag", 256'(tag_out), 256'h0000abcd);
        chk("abc_digest", digest, abc_digest);
        step();
        chk("abc_single", 256'(valid_out), 256'(1'b0));

        // Back-to-back stream of 8 random bundles, tags 0..7
        for (int k = 0; k < 8; k++) begin
            b_s[k]  = rand256();
            b_62[k] = $urandom;
            b_63[k] = $urandom;
            b_h[k]  = rand256();
            b_d[k]  = model(b_s[k], b_62[k], b_63[k], b_h[k]);
        end
        for (int j = 0; j < 10; j++) begin
            if (j < 8) drive(1'b1, b_s[j], b_62[j], b_63[j], b_h[j], 32'(j));
            else drive(1'b0, rand256(), $urandom, $urandom, rand256(), 32'hffff);
            step();
            if (j >= 2) begin
                chk($sformatf("b2b_valid%0d", j - 2), 256'(valid_out), 256'(1'b1));
                chk($sformatf("b2b_tag%0d", j - 2), 256'(tag_out), 256'(j - 2));
                chk($sformatf("b2b_digest%0d", j - 2), digest, b_d[j-2]);
            end
        end
        step();
        chk("b2b_end", 256'(valid_out), 256'(1'b0));

        // Stall with three bundles in flight
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, b_s[j+3], b_62[j+3], b_63[j+3], b_h[j+3], 32'(16 + j));
            step();
        end
        chk("stall_pre_valid", 256'(valid_out), 256'(1'b1));
        chk("stall_pre_digest", digest, b_d[3]);
        write_en = 1'b0;
        drive(1'b1, rand256(), $urandom, $urandom, rand256(), 32'hdead);
        for (int j = 0; j < 5; j++) begin
            step();
            chk($sformatf("stall_valid%0d", j), 256'(valid_out), 256'(1'b1));
            chk($sformatf("stall_tag%0d", j), 256'(tag_out), 256'(16));
            chk($sformatf("stall_digest%0d", j), digest, b_d[3]);
        end
        write_en = 1'b1;
        drive(1'b0, '0, '0, '0, '0, '0);
        step();
        chk("stall_b1_tag", 256'(tag_out), 256'(17));
        chk("stall_b1_digest", digest, b_d[4]);
        step();
        chk("stall_b2_tag", 256'(tag_out), 256'(18));
        chk("stall_b2_digest", digest, b_d[5]);
        step();
        chk("stall_no_dup", 256'(valid_out), 256'(1'b0));

        // Bubble pattern 1,0,1,1,0
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int j = 0; j < 7; j++) begin
            if (j < 5) drive(pat[j], b_s[j], b_62[j], b_63[j], b_h[j], 32'(32 + j));
            else drive(1'b0, '0, '0, '0, '0, '0);
            step();
            if (j >= 2) begin
                chk($sformatf("bubble_valid%0d", j - 2), 256'(valid_out), 256'(pat[j-2]));
                chk($sformatf("bubble_tag%0d", j - 2), 256'(tag_out), 256'(32 + j - 2));
            end
        end

        // Asynchronous reset between edges with three bundles in flight
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, b_s[j], b_62[j], b_63[j], b_h[j], 32'(48 + j));
            step();
        end
        chk("rmid_pre_valid", 256'(valid_out), 256'(1'b1));
        #2;
        RST = 1'b1;
        #1;
        chk("rmid_valid", 256'(valid_out), 256'(1'b0));
        chk("rmid_digest", digest, 256'h0);
        chk("rmid_tag", 256'(tag_out), 256'h0);
        step();
        RST = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0);
        for (int j = 0; j < 4; j++) begin
            step();
            chk($sformatf("rmid_stale%0d", j), 256'(valid_out), 256'(1'b0));
        end
        drive(1'b1, b_s[7], b_62[7], b_63[7], b_h[7], 32'h77);
        step();
        drive(1'b0, '0, '0, '0, '0, '0);
        step();
        chk("rpost_not_early", 256'(valid_out), 256'(1'b0));
        step();
        chk("rpost_valid", 256'(valid_out), 256'(1'b1));
        chk("rpost_digest", digest, b_d[7]);

`ifdef SHA256_TARGET_CMP_EN
        // Target compare: H0 chosen so the top digest byte is 00, then 01, then a bubble
        begin
            logic [255:0] hs, ha, hb, fin;
            logic [31:0]  h62, h63;
            hs  = rand256();
            h62 = $urandom;
            h63 = $urandom;
            fin = tail(hs, h62, h63);
            ha  = rand256();
            ha[255:224] = 32'h00123456 - fin[255:224];
            hb  = ha;
            hb[255:224] = 32'h01234567 - fin[255:224];
            drive(1'b1, hs, h62, h63, ha, 32'h100);
            step();
            drive(1'b1, hs, h62, h63, hb, 32'h101);
            step();
            drive(1'b0, hs, h62, h63, ha, 32'h102);
            step();
            chk("hit_zero_valid", 256'(valid_out), 256'(1'b1));
            chk("hit_zero_top", 256'(digest[255:224]), 256'h00123456);
            chk("hit_zero", 256'(hit), 256'(1'b1));
            drive(1'b0, '0, '0, '0, '0, '0);
            step();
            chk("hit_one_top", 256'(digest[255:224]), 256'h01234567);
            chk("hit_one", 256'(hit), 256'(1'b0));
            step();
            chk("hit_bubble_valid", 256'(valid_out), 256'(1'b0));
            chk("hit_bubble", 256'(hit), 256'(1'b0));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_round_pipeline_62_63.md
Name: sha256_round_pipeline_62_63

Overview:
- Tail of the pipelined SHA-256 compression datapath in the miner.
- Consumes the working state after round 61 plus schedule words W62/W63 from the message-schedule pipeline. Executes rounds 62 and 63, then the feed-forward addition with the chaining value.
- Three register stages with valid/tag tracking; a global enable stalls the whole pipe, matching the schedule pipeline's write_en.

Parameters:
- TAG_W, 32, width of the per-hash tag carried alongside the data (nonce).
- ZERO_BITS, 32, number of leading digest bits that must be zero for a hit. Used only with the optional feature; legal range 1..256.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- write_en  input  1  pipeline advance enable; low = all stages hold.
- valid_in  input  1  input bundle valid; sampled only when write_en=1.
- state_in  input  256  {a,b,c,d,e,f,g,h} after round 61, a in [255:224].
- w62  input  32  schedule word W62.
- w63  input  32  schedule word W63.
- h_init  input  256  chaining value {H0..H7}, H0 in [255:224].
- tag_in  input  TAG_W  tag travelling with the bundle.
- valid_out  output  1  digest valid.
- digest  output  256  {H0'..H7'}, H0' in [255:224].
- tag_out  output  TAG_W  tag matching digest.
- hit  output  1  target hit (only when SHA256_TARGET_CMP_EN is defined; otherwise the port is absent).

Behaviour:
- Single clock CLK; reset RST is asynchronous and active-high.
- Stage 1 (round 62):
  - T1 = h + Σ1(e) + Ch(e,f,g) + K62 + W62; T2 = Σ0(a) + Maj(a,b,c).
  - Outputs: a'=T1+T2, e'=d+T1, b'=a, c'=b, d'=c, f'=e, g'=f, h'=g. All sums mod 2^32.
  - K62=32'hbef9a3f7.
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
- Stage 1 also registers w63, h_init, tag, valid.
- Stage 2 (round 63): same round function with K63=32'hc67178f2 and the registered W63. Carries h_init, tag, valid.
- Stage 3: digest word i = state word i + h_init word i (mod 2^32, per 32-bit lane). Registers digest, tag, valid.
- Latency: exactly 3 enabled cycles from valid_in sample to valid_out.
- Throughput: one bundle per enabled cycle; bubbles (valid_in=0) propagate as valid=0. Data registers still load when write_en=1 regardless of valid (no gating of data path).
- write_en=0: every register, including valid bits, holds. Outputs stay stable for the full stall.
- Reset: all valid bits, digest, tag_out and hit clear to 0 asynchronously. Internal data registers clear to 0.
  - Reset mid-operation discards all in-flight bundles; no valid_out until 3 enabled cycles after a post-reset valid_in.
- Simultaneous deassert of RST and write_en=1 on the same edge: the first sample occurs on the next rising edge after RST low.
- No back-pressure output; the upstream schedule pipeline shares the same write_en.

Optional Feature:
- Macro SHA256_TARGET_CMP_EN.
- Defined:
  - Stage 3 also registers hit = valid && (digest[255 -: ZERO_BITS] == 0), computed from the digest value being loaded.
  - hit resets to 0, holds under stall, and is never 1 when valid_out=0.
- Undefined: the hit port and its comparator are omitted; all other behaviour is identical.

Decomposition:
- Package sha256_pkg:
  - K62/K63 constants, IV constant.
  - Word width 32.
  - Functions for Σ0, Σ1, Ch, Maj.
- Natural sub-module: sha256_round_comb. This is the combinational single round (state, K, W → next state), instantiated twice with different K.
- Feed-forward adder and registers stay in the top module.

Test Plan:
- FIPS 180-4 "abc" single block: drive the model-derived round-61 state, W62, W63, h_init=IV, tag=32'h0000abcd with write_en=1. Exactly 3 cycles later: valid_out=1, tag_out=32'h0000abcd, digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Back-to-back stream: 8 random bundles on consecutive cycles, tags 0..7. Required: 8 consecutive valid_out with tags 0..7 in order, each digest matching the golden model.
- Stall: hold write_en=0 for 5 cycles while 3 bundles are in flight. Outputs frozen, valid_out unchanged. After re-enable, remaining digests emerge with no loss or duplication.
- Bubble pattern: valid_in = 1,0,1,1,0. Required: valid_out reproduces 1,0,1,1,0 delayed by 3 cycles.
- Reset mid-flight: assert RST asynchronously (between edges) with 3 bundles in flight. valid_out, digest, tag_out drop to 0 immediately. No stale output after release.
- SHA256_TARGET_CMP_EN, ZERO_BITS=8:
  - Bundle with model digest top byte 8'h00 → hit=1 with valid_out.
  - Bundle with top byte 8'h01 → hit=0.
  - Bubble → hit=0.
